// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with a runtime baud divisor, runtime
// frame format (5..MaxDataLength data bits, optional even/odd parity), 3-sample
// majority voting, break/overrun detection and a one-entry valid/ready holding
// register on the output.
module uart_rx_cfg #(
  parameter int MaxDataLength = 8,
  parameter int OverSample    = 16,
  parameter int DivWidth      = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_rx,
  input  logic [DivWidth-1:0]      i_baud_div,
  input  logic [3:0]               i_cfg_data_len,
  input  logic                     i_cfg_parity_en,
  input  logic                     i_cfg_parity_odd,
  output logic [MaxDataLength-1:0] o_data,
  output logic                     o_parity_err,
  output logic                     o_frame_err,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_break,
  output logic                     o_overrun,
  output logic                     o_busy
);

  localparam int SW = $clog2(OverSample);

  // Tick positions inside one bit: three samples centred on mid-bit, and the
  // last tick of the bit where the FSM moves on to the next bit.
  localparam logic [SW-1:0] SAMP_A   = SW'(OverSample / 2 - 1);
  localparam logic [SW-1:0] SAMP_B   = SW'(OverSample / 2);
  localparam logic [SW-1:0] SAMP_C   = SW'(OverSample / 2 + 1);
  localparam logic [SW-1:0] BIT_LAST = SW'(OverSample - 1);

  localparam logic [3:0] MIN_LEN = 4'd5;
  localparam logic [3:0] MAX_LEN = 4'(MaxDataLength);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] START      = 3'd1;
  localparam logic [2:0] DATA       = 3'd2;
  localparam logic [2:0] PARITY     = 3'd3;
  localparam logic [2:0] STOP       = 3'd4;
  localparam logic [2:0] BREAK_WAIT = 3'd5;

  logic                     sync1_q, rxs_q;
  logic [2:0]               state_q, state_d;
  logic [DivWidth-1:0]      pre_q, pre_d;
  logic [DivWidth-1:0]      div_q, div_d;
  logic [SW-1:0]            scnt_q, scnt_d;
  logic [3:0]               bit_q, bit_d;
  logic [3:0]               len_q, len_d;
  logic                     pen_q, pen_d;
  logic                     podd_q, podd_d;
  logic [MaxDataLength-1:0] shift_q, shift_d;
  logic                     par_bit_q, par_bit_d;
  logic                     smp1_q, smp1_d;
  logic                     smp2_q, smp2_d;
  logic [MaxDataLength-1:0] data_q, data_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;
  logic                     valid_q, valid_d;
  logic                     break_q, break_d;
  logic                     overrun_q, overrun_d;

  logic                tick;
  logic                maj;
  logic                accept;
  logic                third_smp;
  logic                bit_end;
  logic                is_break;
  logic [3:0]          len_cfg;
  logic [DivWidth-1:0] div_cfg;

  // The configuration is clamped here and only captured at start detect.
  assign len_cfg = (i_cfg_data_len < MIN_LEN) ? MIN_LEN :
                   (i_cfg_data_len > MAX_LEN) ? MAX_LEN : i_cfg_data_len;
  assign div_cfg = (i_baud_div == '0) ? DivWidth'(1) : i_baud_div;

  assign tick      = (state_q != IDLE) && (pre_q == div_q - DivWidth'(1));
  assign maj       = (smp1_q & smp2_q) | (smp1_q & rxs_q) | (smp2_q & rxs_q);
  assign accept    = valid_q & i_ready;
  assign third_smp = tick && (scnt_q == SAMP_C);
  assign bit_end   = tick && (scnt_q == BIT_LAST);
  assign is_break  = (shift_q == '0) && !(pen_q && par_bit_q) && !maj;

  // Two-flop synchroniser for the asynchronous line; idles high like the line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      rxs_q   <= sync1_q;
    end
  end

  // Next-state logic: prescaler, bit timing, majority sampling, frame FSM and
  // the holding register with its overrun/break side effects.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    div_d     = div_q;
    scnt_d    = scnt_q;
    bit_d     = bit_q;
    len_d     = len_q;
    pen_d     = pen_q;
    podd_d    = podd_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    smp1_d    = smp1_q;
    smp2_d    = smp2_q;
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    valid_d   = valid_q;
    break_d   = 1'b0;
    overrun_d = 1'b0;

    if (accept) begin
      valid_d = 1'b0;
    end

    if (state_q == IDLE || tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + DivWidth'(1);
    end

    if (tick) begin
      scnt_d = (scnt_q == BIT_LAST) ? '0 : scnt_q + SW'(1);
      if (scnt_q == SAMP_A) begin
        smp1_d = rxs_q;
      end
      if (scnt_q == SAMP_B) begin
        smp2_d = rxs_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d   = START;
          div_d     = div_cfg;
          len_d     = len_cfg;
          pen_d     = i_cfg_parity_en;
          podd_d    = i_cfg_parity_odd;
          scnt_d    = '0;
          bit_d     = '0;
          shift_d   = '0;
          par_bit_d = 1'b0;
        end
      end
      START: begin
        if (third_smp && maj) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (third_smp) begin
          for (int i = 0; i < MaxDataLength; i++) begin
            if (bit_q == 4'(i)) begin
              shift_d[i] = maj;
            end
          end
        end
        if (bit_end) begin
          if (bit_q == len_q - 4'd1) begin
            state_d = pen_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (third_smp) begin
          par_bit_d = maj;
        end
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (third_smp) begin
          if (is_break) begin
            break_d = 1'b1;
            state_d = BREAK_WAIT;
          end else begin
            state_d = IDLE;
            if (!valid_q || accept) begin
              data_d  = shift_q;
              perr_d  = pen_q && (((^shift_q) ^ par_bit_q) != podd_q);
              ferr_d  = !maj;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end
      BREAK_WAIT: begin
        if (rxs_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any frame in flight and empties the holding register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      div_q     <= DivWidth'(1);
      scnt_q    <= '0;
      bit_q     <= '0;
      len_q     <= MIN_LEN;
      pen_q     <= 1'b0;
      podd_q    <= 1'b0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      smp1_q    <= 1'b1;
      smp2_q    <= 1'b1;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      valid_q   <= 1'b0;
      break_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      div_q     <= div_d;
      scnt_q    <= scnt_d;
      bit_q     <= bit_d;
      len_q     <= len_d;
      pen_q     <= pen_d;
      podd_q    <= podd_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      smp1_q    <= smp1_d;
      smp2_q    <= smp2_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      valid_q   <= valid_d;
      break_q   <= break_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_data       = data_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_valid      = valid_q;
  assign o_break      = break_q;
  assign o_overrun    = overrun_q;
  assign o_busy       = (state_q != IDLE);

endmodule
